// File: rtl/hilo_pkg.sv
// rtl/hilo_pkg.sv - shared types and constants for the HI/LO unit and its divider
package hilo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  localparam int          DIV_ITER = 32;
  localparam logic [31:0] DIV0_QUO = 32'hFFFF_FFFF;

  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic s);
    return s ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/hilo_if.sv
// rtl/hilo_if.sv - HI/LO access and divide-control bundle between ALU stage and hilo_unit
interface hilo_if;
  logic        hilo_we;
  logic [63:0] hilo_wdata;
  logic [63:0] hilo_rdata;
  logic        div_start;
  logic        div_signed;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic        flush;
  logic        div_busy;
  logic        div_done;
  logic        stall;

  modport master (
    output hilo_we, hilo_wdata, div_start, div_signed, div_a, div_b, flush,
    input  hilo_rdata, div_busy, div_done, stall
  );

  modport slave (
    input  hilo_we, hilo_wdata, div_start, div_signed, div_a, div_b, flush,
    output hilo_rdata, div_busy, div_done, stall
  );
endinterface

// File: rtl/hilo_unit_div_iter.sv
// rtl/hilo_unit_div_iter.sv - unsigned restoring shift-subtract core, one quotient bit per cycle
module div_iter
  import hilo_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        flush_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        done_o,
  output logic [31:0] quo_o,
  output logic [31:0] rem_o
);
  localparam int CW = $clog2(DIV_ITER);

  logic [31:0]   rem_q, rem_d, quo_q, quo_d, b_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          run_q, run_d;
  logic [32:0]   trial, diff;

  assign done_o = run_q & (cnt_q == CW'(DIV_ITER - 1));
  assign quo_o  = quo_q;
  assign rem_o  = rem_q;

  // rem < b always holds, so the 33-bit trial stays below 2b and diff[32] is the borrow
  always_comb begin
    trial = {rem_q, quo_q[31]};
    diff  = trial - {1'b0, b_q};
    rem_d = rem_q;
    quo_d = quo_q;
    cnt_d = cnt_q;
    run_d = run_q;
    if (start_i) begin
      rem_d = '0;
      quo_d = a_i;
      cnt_d = '0;
      run_d = 1'b1;
    end else if (flush_i) begin
      run_d = 1'b0;
    end else if (run_q) begin
      rem_d = diff[32] ? trial[31:0] : diff[31:0];
      quo_d = {quo_q[30:0], ~diff[32]};
      cnt_d = cnt_q + 1'b1;
      if (done_o) run_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      b_q   <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
      if (start_i) b_q <= b_i;
    end
  end
endmodule

// File: rtl/hilo_unit.sv
// rtl/hilo_unit.sv - HI/LO registers with read bypass and optional iterative divider (HILO_DIV_EN)
module hilo_unit
  import hilo_pkg::*;
#(
  parameter logic [63:0] RESET_HILO = 64'h0
) (
  input  logic   clk,
  input  logic   rst,
  hilo_if.slave  bus
);
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  assign bus.hilo_rdata = bus.hilo_we ? bus.hilo_wdata : {hi_q, lo_q};

`ifdef HILO_DIV_EN
  state_e      state_q, state_d;
  logic        busy_q, done_q, done_d;
  logic        sa_q, sb_q, dbz_q;
  logic [31:0] araw_q;
  logic        start_acc, sa_in, sb_in, iter_done;
  logic [31:0] quo, rem;

  assign start_acc = (state_q == ST_IDLE) & bus.div_start & ~bus.flush;
  assign sa_in     = bus.div_signed & bus.div_a[31];
  assign sb_in     = bus.div_signed & bus.div_b[31];

  div_iter u_iter (
    .clk     (clk),
    .rst     (rst),
    .start_i (start_acc),
    .flush_i (bus.flush),
    .a_i     (neg_if(bus.div_a, sa_in)),
    .b_i     (neg_if(bus.div_b, sb_in)),
    .done_o  (iter_done),
    .quo_o   (quo),
    .rem_o   (rem)
  );

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.hilo_we) {hi_d, lo_d} = bus.hilo_wdata;
        if (start_acc) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (bus.flush) state_d = ST_IDLE;
        else if (iter_done) state_d = ST_FIX;
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        if (!bus.flush) begin
          hi_d   = dbz_q ? araw_q : neg_if(rem, sa_q);
          lo_d   = dbz_q ? DIV0_QUO : neg_if(quo, sa_q ^ sb_q);
          done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      dbz_q   <= 1'b0;
      araw_q  <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= done_d;
      if (start_acc) begin
        sa_q   <= sa_in;
        sb_q   <= sb_in;
        dbz_q  <= (bus.div_b == 32'd0);
        araw_q <= bus.div_a;
      end
    end
  end

  assign bus.div_busy = busy_q;
  assign bus.div_done = done_q;
  assign bus.stall    = busy_q | (bus.div_start & (state_q == ST_IDLE));
`else
  logic unused_div;
  assign unused_div = ^{bus.div_start, bus.div_signed, bus.div_a, bus.div_b, bus.flush};

  always_comb begin
    {hi_d, lo_d} = {hi_q, lo_q};
    if (bus.hilo_we) {hi_d, lo_d} = bus.hilo_wdata;
  end

  assign bus.div_busy = 1'b0;
  assign bus.div_done = 1'b0;
  assign bus.stall    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {hi_q, lo_q} <= RESET_HILO;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end
endmodule
